// File: rtl/ext_luma_resp.sv
// Luma strip responder: turns one fetch request into 2*SW_ROWS frame-store reads
// with vertical edge replication and horizontal MB clamping, forwarding read data in order.
module ext_luma_resp #(
  parameter int BIT_DEPTH = 8,
  parameter int SW_ROWS   = 48,
  parameter int MAX_OUTST = 4,
  parameter int ADDR_W    = 21
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [7:0]             sys_total_x_i,
  input  logic [7:0]             sys_total_y_i,
  input  logic [ADDR_W-1:0]      frame_base_i,
  input  logic                   ext_req_i,
  input  logic [7:0]             ext_mb_x_i,
  input  logic [7:0]             ext_mb_y_i,
  output logic                   ext_data_v_o,
  output logic [8*BIT_DEPTH-1:0] ext_data_o,
  output logic                   ext_done_o,
  output logic                   mem_req_o,
  output logic [ADDR_W-1:0]      mem_addr_o,
  input  logic                   mem_gnt_i,
  input  logic                   mem_rvalid_i,
  input  logic [8*BIT_DEPTH-1:0] mem_rdata_i
);

  localparam int NBEATS = 2 * SW_ROWS;
  localparam int CNT_W  = $clog2(NBEATS + 1);
  localparam int OUT_W  = $clog2(MAX_OUTST + 1);
  localparam int DW     = 8 * BIT_DEPTH;

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_DRAIN, ST_DONE} state_t;

  state_t            state_q, state_d;
  logic [7:0]        mb_x_q, mb_x_d;
  logic [7:0]        mb_y_q, mb_y_d;
  logic [7:0]        tot_x_q, tot_x_d;
  logic [7:0]        tot_y_q, tot_y_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [CNT_W-1:0]  issued_q, issued_d;
  logic [CNT_W-1:0]  received_q, received_d;
  logic [OUT_W-1:0]  outst_q, outst_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              data_v_q, data_v_d;
  logic [DW-1:0]     data_q, data_d;
  logic              rv_acc, gnt_acc;

  // Row is clamped into the picture so strips above/below the frame replicate the edge rows.
  function automatic logic [ADDR_W-1:0] beat_addr(
    input logic [CNT_W-1:0]  b,
    input logic [7:0]        mbx,
    input logic [7:0]        mby,
    input logic [7:0]        tx,
    input logic [7:0]        ty,
    input logic [ADDR_W-1:0] base
  );
    logic signed [14:0] py;
    logic [12:0]        ymax;
    logic [12:0]        row;
    logic [7:0]         cx;
    py   = $signed({3'b000, mby, 4'b0000}) - 15'sd16 + $signed(15'(b >> 1));
    ymax = {1'b0, ty, 4'b0000} - 13'd1;
    if (py < 0)
      row = '0;
    else if (py > $signed({2'b00, ymax}))
      row = ymax;
    else
      row = py[12:0];
    cx = (mbx < tx) ? mbx : tx - 8'd1;
    return base + ADDR_W'(row) * ADDR_W'({tx, 1'b0}) + ADDR_W'({cx, 1'b0}) + ADDR_W'(b[0]);
  endfunction

  always_comb begin
    state_d    = state_q;
    mb_x_d     = mb_x_q;
    mb_y_d     = mb_y_q;
    tot_x_d    = tot_x_q;
    tot_y_d    = tot_y_q;
    base_d     = base_q;
    issued_d   = issued_q;
    addr_d     = addr_q;
    data_d     = data_q;

    rv_acc  = mem_rvalid_i && ((state_q == ST_ISSUE) || (state_q == ST_DRAIN));
    // A return in the same cycle frees a slot, so a full pipe may still issue.
    mem_req_o = (state_q == ST_ISSUE) && (issued_q < CNT_W'(NBEATS)) &&
                ((outst_q < OUT_W'(MAX_OUTST)) || rv_acc);
    gnt_acc = mem_req_o && mem_gnt_i;

    outst_d    = outst_q + OUT_W'(gnt_acc) - OUT_W'(rv_acc);
    received_d = received_q + CNT_W'(rv_acc);
    data_v_d   = rv_acc;
    if (rv_acc)
      data_d = mem_rdata_i;

    case (state_q)
      ST_IDLE: begin
        if (ext_req_i) begin
          mb_x_d     = ext_mb_x_i;
          mb_y_d     = ext_mb_y_i;
          tot_x_d    = sys_total_x_i;
          tot_y_d    = sys_total_y_i;
          base_d     = frame_base_i;
          issued_d   = '0;
          received_d = '0;
          outst_d    = '0;
          addr_d     = beat_addr('0, ext_mb_x_i, ext_mb_y_i, sys_total_x_i,
                                 sys_total_y_i, frame_base_i);
          state_d    = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (gnt_acc) begin
          issued_d = issued_q + 1'b1;
          if (issued_q == CNT_W'(NBEATS - 1))
            state_d = ST_DRAIN;
          else
            addr_d = beat_addr(issued_q + 1'b1, mb_x_q, mb_y_q, tot_x_q, tot_y_q, base_q);
        end
      end
      ST_DRAIN: begin
        if (received_q == CNT_W'(NBEATS))
          state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      mb_x_q     <= '0;
      mb_y_q     <= '0;
      tot_x_q    <= '0;
      tot_y_q    <= '0;
      base_q     <= '0;
      issued_q   <= '0;
      received_q <= '0;
      outst_q    <= '0;
      addr_q     <= '0;
      data_v_q   <= 1'b0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      mb_x_q     <= mb_x_d;
      mb_y_q     <= mb_y_d;
      tot_x_q    <= tot_x_d;
      tot_y_q    <= tot_y_d;
      base_q     <= base_d;
      issued_q   <= issued_d;
      received_q <= received_d;
      outst_q    <= outst_d;
      addr_q     <= addr_d;
      data_v_q   <= data_v_d;
      data_q     <= data_d;
    end
  end

  assign ext_data_v_o = data_v_q;
  assign ext_data_o   = data_q;
  assign ext_done_o   = (state_q == ST_DONE);
  assign mem_addr_o   = addr_q;

endmodule

// File: tb/tb_ext_luma_resp.sv
// Scoreboard bench for ext_luma_resp: a latency/backpressure memory model plus
// queues of expected addresses and beats filled when each request is issued.
module tb_ext_luma_resp;
  localparam int BIT_DEPTH = 8;
  localparam int SW_ROWS   = 48;
  localparam int MAX_OUTST = 4;
  localparam int ADDR_W    = 21;
  localparam int NB        = 2 * SW_ROWS;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [7:0]             sys_total_x_i, sys_total_y_i;
  logic [ADDR_W-1:0]      frame_base_i;
  logic                   ext_req_i;
  logic [7:0]             ext_mb_x_i, ext_mb_y_i;
  logic                   ext_data_v_o;
  logic [8*BIT_DEPTH-1:0] ext_data_o;
  logic                   ext_done_o;
  logic                   mem_req_o;
  logic [ADDR_W-1:0]      mem_addr_o;
  logic                   mem_gnt_i;
  logic                   mem_rvalid_i;
  logic [8*BIT_DEPTH-1:0] mem_rdata_i;

  ext_luma_resp #(.BIT_DEPTH(BIT_DEPTH), .SW_ROWS(SW_ROWS), .MAX_OUTST(MAX_OUTST),
                  .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .sys_total_x_i(sys_total_x_i), .sys_total_y_i(sys_total_y_i),
    .frame_base_i(frame_base_i), .ext_req_i(ext_req_i),
    .ext_mb_x_i(ext_mb_x_i), .ext_mb_y_i(ext_mb_y_i),
    .ext_data_v_o(ext_data_v_o), .ext_data_o(ext_data_o), .ext_done_o(ext_done_o),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk = ~clk;

  typedef struct {int addr; int due;} rd_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  rd_t         pend[$];
  logic [63:0] exp_q[$];
  int          exp_addr_q[$];
  int          cyc        = 0;
  int          lat        = 1;
  int          gnt_pct    = 100;
  int          beat_cnt   = 0;
  bit          done_seen  = 0;
  int          first_addr = -1;
  int          last_addr  = -1;

  function automatic logic [63:0] data_of(input int a);
    logic [20:0] x;
    x = a[20:0];
    return {x + 21'd7, 1'b1, ~x, x};
  endfunction

  function automatic int exp_addr(input int b, input int mbx, input int mby,
                                  input int tx, input int ty, input int base);
    int py, cx;
    py = mby * 16 - 16 + b / 2;
    if (py < 0) py = 0;
    if (py > ty * 16 - 1) py = ty * 16 - 1;
    cx = (mbx > tx - 1) ? tx - 1 : mbx;
    return (base + py * tx * 2 + cx * 2 + b % 2) & 32'h1FFFFF;
  endfunction

  // Memory model: in-order returns, fixed latency, random grant.
  initial begin
    bit hold_pend;
    int hold_addr;
    hold_pend    = 0;
    hold_addr    = 0;
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = '0;
    forever begin
      @(negedge clk);
      if (rst_n && hold_pend) begin
        n_checks++;
        if (mem_req_o !== 1'b1 || int'(mem_addr_o) != hold_addr) begin
          n_fail++;
          $display("FAIL addr_hold: req %b addr %0d, required req 1 addr %0d",
                   mem_req_o, mem_addr_o, hold_addr);
        end
      end
      hold_pend = rst_n && mem_req_o && !mem_gnt_i;
      hold_addr = int'(mem_addr_o);
      if (rst_n && mem_req_o && mem_gnt_i) begin
        rd_t e;
        int  ea;
        e.addr = int'(mem_addr_o);
        e.due  = cyc + lat;
        n_checks++;
        if (exp_addr_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_grant: addr %0d granted, required no request", e.addr);
        end else begin
          ea = exp_addr_q.pop_front();
          if (e.addr != ea) begin
            n_fail++;
            $display("FAIL grant_addr: addr %0d, required %0d", e.addr, ea);
          end
        end
        n_checks++;
        if (pend.size() + 1 > MAX_OUTST) begin
          n_fail++;
          $display("FAIL outstanding: %0d reads in flight, required <= %0d",
                   pend.size() + 1, MAX_OUTST);
        end
        pend.push_back(e);
        if (first_addr < 0) first_addr = e.addr;
        last_addr = e.addr;
      end
      @(posedge clk);
      cyc++;
      #1;
      if (pend.size() > 0 && pend[0].due <= cyc) begin
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = data_of(pend[0].addr);
        void'(pend.pop_front());
      end else begin
        mem_rvalid_i = 1'b0;
      end
      mem_gnt_i = ($urandom_range(0, 99) < gnt_pct);
    end
  end

  // Output monitor: pops the scoreboard on every beat and checks done placement.
  initial begin
    int          mcyc, last_v;
    logic [63:0] exp;
    mcyc   = 0;
    last_v = -10;
    forever begin
      @(negedge clk);
      mcyc++;
      if (ext_data_v_o === 1'b1) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_beat: data %h, required no beat", ext_data_o);
        end else begin
          exp = exp_q.pop_front();
          if (ext_data_o !== exp) begin
            n_fail++;
            $display("FAIL beat_data: beat %0d data %h, required %h", beat_cnt, ext_data_o, exp);
          end
        end
        beat_cnt++;
        last_v = mcyc;
      end
      if (ext_done_o === 1'b1) begin
        n_checks++;
        if (ext_data_v_o !== 1'b0 || last_v != mcyc - 1 || exp_q.size() != 0) begin
          n_fail++;
          $display("FAIL done_timing: data_v %b last beat %0d cycles ago, %0d beats left, required 0/1/0",
                   ext_data_v_o, mcyc - last_v, exp_q.size());
        end
        done_seen = 1;
      end
    end
  end

  task automatic do_reset_pulse();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic run_strip(input int mbx, input int mby, input int tx, input int ty,
                           input int base, input int l, input int pct,
                           input int busy_beat, input int rst_beat, output bit aborted);
    int  a0;
    bit  busy_sent;
    aborted    = 0;
    busy_sent  = 0;
    first_addr = -1;
    last_addr  = -1;
    lat        = l;
    gnt_pct    = pct;
    beat_cnt   = 0;
    done_seen  = 0;
    for (int b = 0; b < NB; b++) begin
      exp_addr_q.push_back(exp_addr(b, mbx, mby, tx, ty, base));
      exp_q.push_back(data_of(exp_addr(b, mbx, mby, tx, ty, base)));
    end
    a0 = exp_addr(0, mbx, mby, tx, ty, base);
    @(posedge clk);
    #1;
    sys_total_x_i = 8'(tx);
    sys_total_y_i = 8'(ty);
    frame_base_i  = ADDR_W'(base);
    ext_mb_x_i    = 8'(mbx);
    ext_mb_y_i    = 8'(mby);
    ext_req_i     = 1'b1;
    @(posedge clk);
    #1 ext_req_i = 1'b0;
    @(negedge clk);
    n_checks++;
    if (mem_req_o !== 1'b1 || int'(mem_addr_o) != a0) begin
      n_fail++;
      $display("FAIL req_latency: req %b addr %0d one cycle after request, required 1 / %0d",
               mem_req_o, mem_addr_o, a0);
    end
    for (int i = 0; i < 3000 && !done_seen; i++) begin
      @(posedge clk);
      #1;
      if (busy_beat >= 0 && beat_cnt >= busy_beat && !busy_sent) begin
        ext_mb_x_i    = 8'd0;
        ext_mb_y_i    = 8'd0;
        sys_total_x_i = 8'd1;
        ext_req_i     = 1'b1;
        busy_sent     = 1;
      end else begin
        ext_req_i = 1'b0;
      end
      if (rst_beat >= 0 && beat_cnt >= rst_beat) begin
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (ext_data_v_o !== 1'b0 || ext_data_o !== '0 || ext_done_o !== 1'b0 ||
            mem_req_o !== 1'b0 || mem_addr_o !== '0) begin
          n_fail++;
          $display("FAIL async_reset: v %b data %h done %b req %b addr %0d, required all 0",
                   ext_data_v_o, ext_data_o, ext_done_o, mem_req_o, mem_addr_o);
        end
        exp_q.delete();
        exp_addr_q.delete();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        aborted = 1;
        return;
      end
    end
    ext_req_i = 1'b0;
    n_checks++;
    if (!done_seen) begin
      n_fail++;
      $display("FAIL strip_timeout: no done after %0d beats, required done", beat_cnt);
    end
    n_checks++;
    if (beat_cnt != NB) begin
      n_fail++;
      $display("FAIL beat_count: %0d beats, required %0d", beat_cnt, NB);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (ext_data_v_o !== 1'b0 || ext_data_o !== '0 || ext_done_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_out: v %b data %h done %b, required 0", ext_data_v_o, ext_data_o, ext_done_o);
    end
    n_checks++;
    if (mem_req_o !== 1'b0 || mem_addr_o !== '0) begin
      n_fail++;
      $display("FAIL reset_mem: req %b addr %0d, required 0", mem_req_o, mem_addr_o);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (mem_req_o !== 1'b0 || ext_data_v_o !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_quiet: req %b v %b with no request, required 0", mem_req_o, ext_data_v_o);
    end
  endtask

  task automatic test_interior();
    bit ab;
    run_strip(5, 5, 20, 15, 0, 1, 100, -1, -1, ab);
    n_checks++;
    if (first_addr != 2570 || last_addr != 4451) begin
      n_fail++;
      $display("FAIL interior_addr: first %0d last %0d, required 2570 / 4451", first_addr, last_addr);
    end
  endtask

  task automatic test_edges();
    bit ab;
    run_strip(3, 0, 20, 15, 100, 1, 100, -1, -1, ab);
    n_checks++;
    if (first_addr != 106) begin
      n_fail++;
      $display("FAIL top_edge: first %0d, required 106", first_addr);
    end
    run_strip(3, 14, 20, 15, 100, 1, 100, -1, -1, ab);
    n_checks++;
    if (last_addr != 100 + 239 * 40 + 7) begin
      n_fail++;
      $display("FAIL bottom_edge: last %0d, required %0d", last_addr, 100 + 239 * 40 + 7);
    end
  endtask

  task automatic test_clamp();
    bit ab;
    run_strip(22, 7, 20, 15, 0, 1, 100, -1, -1, ab);
    n_checks++;
    if (first_addr != 3878 || last_addr != 5759) begin
      n_fail++;
      $display("FAIL h_clamp: first %0d last %0d, required 3878 / 5759", first_addr, last_addr);
    end
  endtask

  task automatic test_backpressure();
    bit ab;
    run_strip(5, 5, 20, 15, 32'h1FFF00, 6, 30, -1, -1, ab);
  endtask

  task automatic test_busy();
    bit ab;
    run_strip(5, 5, 20, 15, 0, 1, 100, 10, -1, ab);
  endtask

  task automatic test_reset_mid();
    bit ab;
    run_strip(5, 5, 20, 15, 0, 3, 100, -1, 40, ab);
    n_checks++;
    if (!ab) begin
      n_fail++;
      $display("FAIL reset_reach: strip ended at %0d beats before reset point, required 40", beat_cnt);
    end
    repeat (12) @(posedge clk);
    run_strip(8, 2, 20, 15, 50, 1, 100, -1, -1, ab);
  endtask

  task automatic test_back_to_back();
    bit ab;
    run_strip(0, 0, 1, 1, 7, 2, 100, -1, -1, ab);
    run_strip(19, 14, 20, 15, 900, 4, 70, -1, -1, ab);
  endtask

  initial begin
    rst_n         = 1'b0;
    sys_total_x_i = '0;
    sys_total_y_i = '0;
    frame_base_i  = '0;
    ext_req_i     = 1'b0;
    ext_mb_x_i    = '0;
    ext_mb_y_i    = '0;
    test_reset();
    test_interior();
    test_edges();
    test_clamp();
    test_backpressure();
    test_busy();
    test_reset_mid();
    test_back_to_back();
    repeat (5) @(posedge clk);
    n_checks++;
    if (exp_q.size() != 0 || exp_addr_q.size() != 0) begin
      n_fail++;
      $display("FAIL leftover: %0d beats %0d addrs still expected, required 0",
               exp_q.size(), exp_addr_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
